// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   - Avalon register word addresses
//   - CTRL field bit positions and switch bit roles
//   - FSM state and pattern enumerations
//   - pattern seed values and a seed lookup helper
package led_seq_pkg;

  // Register map (word addresses)
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_LED_SW = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL field positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MODE_BIT   = 1;
  localparam int CTRL_USE_SW_BIT = 2;
  localparam int CTRL_PAT_LSB    = 4;

  // Synchronised switch roles ([1:0] is the pattern code)
  localparam int SW_INVERT_BIT = 2;
  localparam int SW_PAUSE_BIT  = 3;

  // Encoding is visible in STATUS[13:12]
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOFT = 2'd1,
    AUTO = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } pat_t;

  localparam logic [7:0] SEED_ROT_L  = 8'h01;
  localparam logic [7:0] SEED_ROT_R  = 8'h80;
  localparam logic [7:0] SEED_BOUNCE = 8'h01;
  localparam logic [7:0] SEED_COUNT  = 8'h00;

  function automatic logic [7:0] pattern_seed(input pat_t p);
    logic [7:0] s;
    case (p)
      ROT_L:   s = SEED_ROT_L;
      ROT_R:   s = SEED_ROT_R;
      BOUNCE:  s = SEED_BOUNCE;
      default: s = SEED_COUNT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step-rate timer for the pattern sequencer.
// Counts clk cycles and pulses tick on the cycle the count reaches
// max(period,1)-1; the count wraps to 0 on that same edge.
//   clk    : system clock
//   srst   : synchronous active-high reset
//   period : cycles per step (0 behaves as 1)
//   clear  : forces the count to 0 and suppresses tick this cycle
//   pause  : holds the count and suppresses tick
//   tick   : one step is due at the coming edge
module led_step_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [CNT_W-1:0] period,
  input  logic             clear,
  input  logic             pause,
  output logic             tick
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] last_count;
  logic             at_last;

  // PERIOD=0 collapses onto PERIOD=1: last count is 0 either way.
  assign last_count = (period == '0) ? '0 : period - CNT_W'(1);
  assign at_last    = (count_reg == last_count);
  assign tick       = !clear && !pause && at_last;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!pause) begin
      count_reg <= at_last ? '0 : count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED controller: drives the board LEDs either from a software
// value (SOFT) or from a stepping hardware pattern (AUTO), or blanks them
// (IDLE).
//   clk, reset            : system clock, synchronous active-high reset
//   avs_address/read/write/writedata/readdata
//                         : Avalon-MM slave, read latency 1, no waitrequest
//                           0 CTRL, 1 PERIOD, 2 LED_SW, 3 STATUS (RO)
//   switches              : asynchronous board switches
//                           [1:0] pattern, [2] invert, [3] pause
//   leds                  : registered LED drive
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD = 50000000,
  parameter int          SYNC_STAGES    = 2,
  parameter int          LED_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [3:0]       switches,
  output logic [LED_W-1:0] leds
);

  localparam int SW_W = 4;

  // ---------------- switch synchroniser ----------------
  logic [SYNC_STAGES-1:0][SW_W-1:0] sync_reg;
  logic [SW_W-1:0]                  sw_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], switches};
    end
  end

  assign sw_sync = sync_reg[SYNC_STAGES-1];

  // ---------------- register file ----------------
  logic             enable_reg;
  logic             mode_reg;
  logic             use_sw_reg;
  pat_t             pat_reg;
  logic [31:0]      period_reg;
  logic [LED_W-1:0] led_sw_reg;

  logic wr_ctrl;
  logic wr_period;
  logic wr_led_sw;

  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign wr_period = avs_write && (avs_address == ADDR_PERIOD);
  assign wr_led_sw = avs_write && (avs_address == ADDR_LED_SW);

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_reg <= 1'b0;
      mode_reg   <= 1'b0;
      use_sw_reg <= 1'b0;
      pat_reg    <= ROT_L;
      period_reg <= 32'(DEFAULT_PERIOD);
      led_sw_reg <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_reg <= avs_writedata[CTRL_ENABLE_BIT];
        mode_reg   <= avs_writedata[CTRL_MODE_BIT];
        use_sw_reg <= avs_writedata[CTRL_USE_SW_BIT];
        pat_reg    <= pat_t'(avs_writedata[CTRL_PAT_LSB +: 2]);
      end
      if (wr_period) begin
        period_reg <= avs_writedata;
      end
      if (wr_led_sw) begin
        led_sw_reg <= avs_writedata[LED_W-1:0];
      end
    end
  end

  // ---------------- FSM ----------------
  state_t state_reg, state_next;
  pat_t   pat_sel;
  pat_t   pat_active_reg;
  logic   load_seed;

  assign pat_sel = use_sw_reg ? pat_t'(sw_sync[1:0]) : pat_reg;

  always_comb begin
    state_next = state_reg;
    if (!enable_reg) begin
      state_next = IDLE;
    end else if (mode_reg) begin
      state_next = AUTO;
    end else begin
      state_next = SOFT;
    end
  end

  // Reseed on entry to AUTO and whenever the selected pattern changes
  // while staying in AUTO.
  assign load_seed = (state_next == AUTO) &&
                     ((state_reg != AUTO) || (pat_sel != pat_active_reg));

  // ---------------- step timer ----------------
  logic tick;

  led_step_timer #(
    .CNT_W(32)
  ) u_timer (
    .clk   (clk),
    .srst  (reset),
    .period(period_reg),
    .clear (wr_period || load_seed),
    .pause (sw_sync[SW_PAUSE_BIT]),
    .tick  (tick)
  );

  // ---------------- pattern generator ----------------
  logic [LED_W-1:0] pattern_reg, pattern_next;
  logic             dir_left_reg, dir_left_next;

  always_comb begin
    pattern_next  = pattern_reg;
    dir_left_next = dir_left_reg;
    if (load_seed) begin
      pattern_next  = pattern_seed(pat_sel);
      dir_left_next = 1'b1;
    end else if ((state_reg == AUTO) && tick) begin
      case (pat_active_reg)
        ROT_L:  pattern_next = {pattern_reg[LED_W-2:0], pattern_reg[LED_W-1]};
        ROT_R:  pattern_next = {pattern_reg[0], pattern_reg[LED_W-1:1]};
        COUNT:  pattern_next = pattern_reg + LED_W'(1);
        BOUNCE: begin
          // Turn around at the end positions instead of wrapping.
          if (dir_left_reg) begin
            if (pattern_reg == 8'h80) begin
              pattern_next  = 8'h40;
              dir_left_next = 1'b0;
            end else begin
              pattern_next = pattern_reg << 1;
            end
          end else begin
            if (pattern_reg == 8'h01) begin
              pattern_next  = 8'h02;
              dir_left_next = 1'b1;
            end else begin
              pattern_next = pattern_reg >> 1;
            end
          end
        end
        default: pattern_next = pattern_reg;
      endcase
    end
  end

  // ---------------- LED output ----------------
  logic [LED_W-1:0] led_base;
  logic [LED_W-1:0] led_drive;
  logic [LED_W-1:0] leds_reg;

  always_comb begin
    led_base = '0;
    case (state_reg)
      SOFT:    led_base = led_sw_reg;
      AUTO:    led_base = pattern_reg;
      default: led_base = '0;
    endcase
  end

  // Invert switch applies to every lit state; IDLE stays dark.
  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi++) begin : g_led
      assign led_drive[gi] = (state_reg != IDLE) &&
                             (led_base[gi] ^ sw_sync[SW_INVERT_BIT]);
    end
  endgenerate

  // ---------------- read mux ----------------
  logic [31:0] read_mux;
  logic [31:0] readdata_reg;

  always_comb begin
    read_mux = '0;
    case (avs_address)
      ADDR_CTRL: begin
        read_mux[CTRL_ENABLE_BIT]       = enable_reg;
        read_mux[CTRL_MODE_BIT]         = mode_reg;
        read_mux[CTRL_USE_SW_BIT]       = use_sw_reg;
        read_mux[CTRL_PAT_LSB +: 2]     = pat_reg;
      end
      ADDR_PERIOD: read_mux = period_reg;
      ADDR_LED_SW: read_mux[LED_W-1:0] = led_sw_reg;
      default: begin
        read_mux[7:0]   = leds_reg;
        read_mux[11:8]  = sw_sync;
        read_mux[13:12] = state_reg;
      end
    endcase
  end

  // ---------------- sequential state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pat_active_reg <= ROT_L;
      pattern_reg    <= '0;
      dir_left_reg   <= 1'b1;
      leds_reg       <= '0;
      readdata_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pattern_reg  <= pattern_next;
      dir_left_reg <= dir_left_next;
      leds_reg     <= led_drive;
      if (load_seed) begin
        pat_active_reg <= pat_sel;
      end
      // Read mux sees pre-write values, so a colliding write returns old data.
      if (avs_read) begin
        readdata_reg <= read_mux;
      end
    end
  end

  assign leds         = leds_reg;
  assign avs_readdata = readdata_reg;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [3:0]  switches;
  logic [7:0]  leds;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .DEFAULT_PERIOD(50000000),
    .SYNC_STAGES(SYNC),
    .LED_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .switches(switches),
    .leds(leds)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en, m_mode, m_usesw;
  logic [1:0]  m_patreg, m_patact;
  logic [31:0] m_period, m_rdata;
  logic [7:0]  m_ledsw, m_val, m_leds;
  logic [3:0]  m_sw [SYNC];
  int          m_state;        // 0 idle, 1 soft, 2 auto
  bit          m_left;
  longint      m_cnt;

  logic [3:0]  t_sw;
  logic [1:0]  t_pat;
  int          t_des;
  bit          t_load, t_wp, t_tick;
  longint      t_eff;
  logic [7:0]  t_base;

  always @(posedge clk) begin
    if (reset) begin
      m_en = 0; m_mode = 0; m_usesw = 0; m_patreg = 0; m_patact = 0;
      m_period = 50000000; m_ledsw = 0; m_val = 0; m_leds = 0; m_rdata = 0;
      m_state = 0; m_left = 1; m_cnt = 0;
      for (int k = 0; k < SYNC; k++) m_sw[k] = 4'h0;
    end else begin
      t_sw  = m_sw[SYNC-1];
      t_pat = m_usesw ? t_sw[1:0] : m_patreg;
      t_des = !m_en ? 0 : (m_mode ? 2 : 1);
      if (avs_read) begin
        case (avs_address)
          2'd0: m_rdata = 32'(m_en) + 32'(m_mode) * 2 + 32'(m_usesw) * 4 + 32'(m_patreg) * 16;
          2'd1: m_rdata = m_period;
          2'd2: m_rdata = 32'(m_ledsw);
          default: m_rdata = 32'(m_leds) + 32'(t_sw) * 256 + 32'(m_state) * 4096;
        endcase
      end
      t_base = (m_state == 1) ? m_ledsw : m_val;
      m_leds = (m_state == 0) ? 8'h00 : (t_sw[2] ? ~t_base : t_base);
      t_load = (t_des == 2) && (m_state != 2 || t_pat != m_patact);
      t_wp   = avs_write && avs_address == 2'd1;
      t_eff  = (m_period == 0) ? 1 : longint'(m_period);
      t_tick = !t_sw[3] && (m_cnt == t_eff - 1) && !t_load && !t_wp;
      if (t_load || t_wp) m_cnt = 0;
      else if (!t_sw[3]) m_cnt = (m_cnt + 1) % t_eff;
      if (t_load) begin
        m_patact = t_pat;
        m_left   = 1;
        case (t_pat)
          2'd0: m_val = 8'h01;
          2'd1: m_val = 8'h80;
          2'd2: m_val = 8'h01;
          default: m_val = 8'h00;
        endcase
      end else if (m_state == 2 && t_tick) begin
        case (m_patact)
          2'd0: m_val = 8'((m_val * 2) % 256 + m_val / 128);
          2'd1: m_val = 8'(m_val / 2 + (m_val % 2) * 128);
          2'd3: m_val = 8'((m_val + 1) % 256);
          default: begin
            if (m_left && m_val == 8'h80) begin m_val = 8'h40; m_left = 0; end
            else if (!m_left && m_val == 8'h01) begin m_val = 8'h02; m_left = 1; end
            else if (m_left) m_val = 8'(m_val * 2);
            else m_val = 8'(m_val / 2);
          end
        endcase
      end
      if (avs_write) begin
        case (avs_address)
          2'd0: begin
            m_en = avs_writedata[0]; m_mode = avs_writedata[1];
            m_usesw = avs_writedata[2]; m_patreg = avs_writedata[5:4];
          end
          2'd1: m_period = avs_writedata;
          2'd2: m_ledsw = avs_writedata[7:0];
          default: ;
        endcase
      end
      m_state = t_des;
      for (int k = SYNC - 1; k > 0; k--) m_sw[k] = m_sw[k-1];
      m_sw[0] = switches;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("leds_vs_model", 32'(leds), 32'(m_leds));
      check("readdata_vs_model", avs_readdata, m_rdata);
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_rdwr(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = wd; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_leds(input logic [7:0] v, input string nm);
    int n;
    n = 0;
    while (leds !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(leds === v), 32'd1);
  endtask

  logic [7:0] bounce_exp [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    logic [31:0] d;
    logic [7:0]  e;
    int          run;

    reset = 1'b1; avs_address = 0; avs_read = 0; avs_write = 0;
    avs_writedata = 0; switches = 0;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);

    bus_rd(2'd1, d);
    check("period_default", d, 32'd50000000);

    // SOFT mode and output inversion
    bus_wr(2'd1, 32'd4);
    bus_wr(2'd2, 32'hA5);
    bus_wr(2'd0, 32'h1);
    repeat (3) @(negedge clk);
    check("soft_leds", 32'(leds), 32'hA5);
    switches = 4'b0100;
    repeat (4) @(negedge clk);
    check("soft_inverted", 32'(leds), 32'h5A);
    switches = 4'b0000;
    repeat (4) @(negedge clk);

    // Rotate-left, each value held 4 cycles
    bus_wr(2'd0, 32'h3);
    wait_leds(8'h01, "rot_seed_seen");
    for (int i = 0; i < 36; i++) begin
      if (i > 0) @(negedge clk);
      e = 8'h01 << ((i / 4) % 8);
      check("rot_seq", 32'(leds), 32'(e));
    end

    // Bounce at one step per cycle
    bus_wr(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    bus_wr(2'd1, 32'd1);
    bus_wr(2'd0, 32'h23);
    wait_leds(8'h01, "bounce_seed_seen");
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      check("bounce_seq", 32'(leds), 32'(bounce_exp[i]));
    end

    // Count selected by switches, including FF -> 00 wrap
    bus_wr(2'd0, 32'h0);
    repeat (3) @(negedge clk);
    switches = 4'b0011;
    repeat (3) @(negedge clk);
    bus_wr(2'd0, 32'h7);
    wait_leds(8'h01, "count_first_step");
    for (int i = 0; i < 257; i++) begin
      if (i > 0) @(negedge clk);
      e = 8'(i + 1);
      check("count_seq", 32'(leds), 32'(e));
    end

    // Pause then resume
    switches = 4'b1011;
    repeat (6) @(negedge clk);
    bus_rd(2'd3, d);
    check("status_sw", 32'(d[11:8]), 32'hB);
    check("status_state", 32'(d[13:12]), 32'd2);
    switches = 4'b0011;
    repeat (6) @(negedge clk);

    // Colliding read and write: write lands, read returns old CTRL
    bus_rdwr(2'd0, 32'h0, d);
    check("rdwr_old_ctrl", d, 32'h7);
    switches = 4'b0000;
    repeat (3) @(negedge clk);

    // PERIOD write on the tick cycle: no step, count restarts
    bus_wr(2'd1, 32'd4);
    bus_wr(2'd0, 32'h3);
    wait_leds(8'h01, "tick_seed_seen");
    run = 1;
    @(negedge clk);
    if (leds === 8'h01) run++;
    @(negedge clk);
    if (leds === 8'h01) run++;
    avs_address = 2'd1; avs_writedata = 32'd4; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (leds !== 8'h01) break;
      run++;
      @(negedge clk);
    end
    check("tick_hold_cycles", 32'(run), 32'd8);
    check("tick_after_hold", 32'(leds), 32'h02);

    // Reset mid-run with a pending read
    repeat (5) @(negedge clk);
    @(negedge clk);
    reset = 1'b1; avs_read = 1'b1; avs_address = 2'd0;
    @(negedge clk);
    reset = 1'b0; avs_read = 1'b0;
    check("midreset_leds", 32'(leds), 32'h0);
    check("midreset_readdata", avs_readdata, 32'h0);
    bus_rd(2'd0, d);
    check("midreset_ctrl", d, 32'h0);
    bus_rd(2'd1, d);
    check("midreset_period", d, 32'd50000000);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
